dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port. Accepts one load/store
//  request at a time over a valid/ready handshake and inserts a programmable
//  number of wait states. Performs byte/half/word lane selection, and sign- or
//  zero-extension, on the memory side.
//  Returns the load result, the raw addressed word, and an alignment error flag.
//  Replaces the zero-latency data memory when a multi-cycle memory is modelled.
// PARAMETERS
//  DEPTH_LOG2   6   log2 of memory depth in 32-bit words (64 words)
//  WAIT_CYCLES  2   wait states between accept and access; 0..15 legal
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept; high only in IDLE
//  req_we       in   1   1 = store, 0 = load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, right-justified for byte/half
//  req_bytes    in   2   size: 00 = word, 01 = half, 10 = byte, 11 = reserved (treated as word)
//  req_signed   in   1   loads: 1 = sign-extend, 0 = zero-extend
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   core accepts the response
//  rsp_rdata    out  32  extended load data; 0 for stores and errors
//  rsp_raw      out  32  full addressed word before lane select; 0 for stores
//  rsp_err      out  1   misaligned access; the access was suppressed
// BEHAVIOUR
//  Reset (async, reset=0): FSM=IDLE, wait counter=0, all outputs 0 except req_ready=1.
//    Memory array is not cleared.
//  FSM states and transitions:
//   IDLE: req_ready=1. On req_valid=1, latch we/addr/wdata/bytes/signed and load counter=WAIT_CYCLES.
//     Go to BUSY, or to ACCESS if WAIT_CYCLES=0.
//   BUSY: req_ready=0. Decrement counter each cycle; when counter==1, go to ACCESS.
//   ACCESS: perform the single array read or write, register the response, go to RESP.
//   RESP: rsp_valid=1 with stable rsp_* outputs. On rsp_ready=1, go to IDLE.
//     rsp_valid stays high until that handshake.
//  Latency: accept at edge N gives rsp_valid high after edge N+WAIT_CYCLES+1.
//    With WAIT_CYCLES=0, rsp_valid is high one cycle after accept.
//    req_ready is low from the accept edge until the response handshake; no overlap.
//  Indexing: word index = req_addr[DEPTH_LOG2+1:2]. Upper bits are ignored (address wraps).
//  Byte lanes are little-endian: byte k = word[8k+7:8k]; half h = word[16h+15:16h].
//  Store: writes only the selected lanes, with wdata[7:0] or wdata[15:0] replicated to the lane.
//  Load: lane = addr[1:0] (byte) or addr[1] (half), extended per req_signed.
//  Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
//    Array is untouched, rsp_err=1, rsp_rdata=0, rsp_raw=0. Handshake is unchanged.
//  Reset mid-operation: a request in BUSY is dropped and its store is NOT committed.
//    A store already in RESP has been committed.
//  Simultaneous req_valid in RESP: ignored, since req_ready=0; the core must hold it.
// STRUCTURE
//  Shared package dmem_pkg:
//    size codes SZ_WORD/SZ_HALF/SZ_BYTE.
//    FSM state encoding: IDLE=2'd0, BUSY=2'd1, ACCESS=2'd2, RESP=2'd3.
//  Sub-module lane_extract (combinational):
//    (word, addr[1:0], bytes, signed) -> extended data.
//  Sub-module lane_extract also provides the write byte-enable mask.
//  Top level contains the FSM, wait counter, request latch, register array and response registers.
// TESTING
//  1. Store word 0xDEADBEEF @0x10, then load word @0x10:
//     rsp_rdata=0xDEADBEEF; rsp_valid rises 3 cycles after each accept.
//  2. Store half 0x8001 @0x22, then signed load half @0x22 -> 0xFFFF8001.
//     Unsigned load half @0x22 -> 0x00008001; rsp_raw=0x8001xxxx.
//  3. Word 0x11223344 @0x30, store byte 0xAA @0x31, load word -> 0x1122AA44.
//     Signed load byte @0x31 -> 0xFFFFFFAA.
//  4. Load word @0x12: rsp_err=1, rdata=0.
//     Store half @0x13: rsp_err=1, and a following load shows memory unchanged.
//  5. Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_rdata stay stable and req_ready stays 0.
//     Then raise rsp_ready: IDLE with req_ready=1 on the next cycle.
//  6. Store 0x55 to a word, assert reset=0 during BUSY: outputs go to reset values at once.
//     A reload after reset returns the old value.
//     Repeat with WAIT_CYCLES=0 to check one-cycle latency.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: size codes, FSM state
// encoding, counter width and the store-data lane replication helper.
package dmem_pkg;

  // Access size codes carried on req_bytes; the reserved code behaves as a word
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Wide enough for 0..15 wait states
  localparam int CNT_W = 4;

  // A half on an odd byte, or a word off a word boundary, cannot be serviced
  function automatic logic is_misaligned(input logic [1:0] bytes,
                                         input logic [1:0] addr_lo);
    case (size_e'(bytes))
      SZ_HALF: return addr_lo[0];
      SZ_BYTE: return 1'b0;
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

  // Store data arrives right-justified; copy it onto every lane so the byte
  // enables alone decide which lanes of the word are written
  function automatic logic [31:0] lane_wdata(input logic [1:0]  bytes,
                                             input logic [31:0] wdata);
    case (size_e'(bytes))
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_lane_extract.sv
// Little-endian lane selection for loads (with sign/zero extension) and the
// matching byte-enable mask for stores.
module lane_extract
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  bytes,
  input  logic        sgn,
  output logic [31:0] data,
  output logic [3:0]  be
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed lane, extend it to 32 bits and build the write mask
  always_comb begin
    sel_byte = word[{addr_lo, 3'b000} +: 8];
    sel_half = addr_lo[1] ? word[31:16] : word[15:0];
    data     = word;
    be       = 4'hF;
    case (size_e'(bytes))
      SZ_BYTE: begin
        data = {{24{sgn & sel_byte[7]}}, sel_byte};
        be   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        data = {{16{sgn & sel_half[15]}}, sel_half};
        be   = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        data = word;
        be   = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: one request at a time,
// a programmable number of wait states, then a single array access whose
// result is held until the core takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_bytes,
  input  logic        req_signed,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [31:0] rsp_raw,
  output logic        rsp_err
);

  localparam int             DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  accept;
  logic                  do_access;

  logic                  lat_we;
  logic [DEPTH_LOG2+1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [1:0]            lat_bytes;
  logic                  lat_signed;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;
  logic [31:0]           ld_data;
  logic [31:0]           wr_word;
  logic [3:0]            wr_be;
  logic                  misaligned;

  // Address bits above the array wrap around and are deliberately ignored
  logic                  addr_unused;
  assign addr_unused = ^req_addr[31:DEPTH_LOG2+2];

  assign idx        = lat_addr[DEPTH_LOG2+1:2];
  assign rd_word    = mem[idx];
  assign misaligned = is_misaligned(lat_bytes, lat_addr[1:0]);
  assign wr_word    = lane_wdata(lat_bytes, lat_wdata);
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);

  lane_extract u_lane (
    .word    (rd_word),
    .addr_lo (lat_addr[1:0]),
    .bytes   (lat_bytes),
    .sgn     (lat_signed),
    .data    (ld_data),
    .be      (wr_be)
  );

  // Next-state and handshake decode; the counter only matters while BUSY
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          cnt_next   = WAIT_INIT;
          state_next = (WAIT_CYCLES == 0) ? ACCESS : BUSY;
        end
      end
      BUSY: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        do_access  = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and wait counter; reset abandons any request still waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the request on the accepting edge so the core may change its bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_bytes  <= '0;
      lat_signed <= 1'b0;
    end else if (accept) begin
      lat_we     <= req_we;
      lat_addr   <= req_addr[DEPTH_LOG2+1:0];
      lat_wdata  <= req_wdata;
      lat_bytes  <= req_bytes;
      lat_signed <= req_signed;
    end
  end

  // Array write happens only in ACCESS, so a request dropped by reset never commits
  always_ff @(posedge clk) begin
    if (do_access && lat_we && !misaligned) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem[idx][8*k +: 8] <= wr_word[8*k +: 8];
        end
      end
    end
  end

  // Response registers stay frozen through RESP until the next access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_raw   <= '0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      if (misaligned) begin
        rsp_rdata <= '0;
        rsp_raw   <= '0;
        rsp_err   <= 1'b1;
      end else if (lat_we) begin
        rsp_rdata <= '0;
        rsp_raw   <= '0;
        rsp_err   <= 1'b0;
      end else begin
        rsp_rdata <= ld_data;
        rsp_raw   <= rd_word;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule
